// File: rtl/rv32_scoreboard_hazard_unit.sv
// Scoreboard RAW/WAW hazard unit for the RV32 decode stage.
// Keeps one entry per architectural register (x1..x31): valid, long, age, ready_age.
// Produces a decode stall and per-operand bypass selects (0 = regfile, k = pipeline buffer k).
// Optional statistics counters are compiled in when RV32_HAZARD_STATS_EN is defined.
module rv32_scoreboard_hazard_unit #(
  parameter int unsigned NUM_RS         = 2,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned AGE_W          = $clog2(NUM_FWD_STAGES) + 1,
  parameter int unsigned SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    pipe_advance_i,
  input  logic [NUM_RS-1:0]       use_rs_i,
  input  logic [NUM_RS*5-1:0]     rs_id_i,
  input  logic                    issue_valid_i,
  input  logic                    issue_wb_i,
  input  logic [4:0]              issue_rd_i,
  input  logic                    issue_long_i,
  input  logic [AGE_W-1:0]        issue_ready_age_i,
  input  logic                    lu_done_i,
  input  logic [4:0]              lu_rd_i,
  output logic                    stall_o,
  output logic [NUM_RS*SEL_W-1:0] bypass_sel_o
`ifdef RV32_HAZARD_STATS_EN
  ,
  output logic [31:0]             stat_stall_cycles_o,
  output logic [31:0]             stat_loaduse_o,
  output logic [31:0]             stat_waw_o
`endif
);

  localparam logic [AGE_W-1:0] LastAge = AGE_W'(NUM_FWD_STAGES - 1);

  logic [31:0]      valid_q, valid_d;
  logic [31:0]      long_q, long_d;
  logic [AGE_W-1:0] age_q [32];
  logic [AGE_W-1:0] age_d [32];
  logic [AGE_W-1:0] rdy_q [32];
  logic [AGE_W-1:0] rdy_d [32];

  logic [NUM_RS-1:0] long_stall;
  logic [NUM_RS-1:0] ld_stall;
  logic              waw_stall;
  logic              issue_fire;

  // Per-operand hazard check and bypass select; purely combinational from state and inputs.
  always_comb begin
    long_stall   = '0;
    ld_stall     = '0;
    bypass_sel_o = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (use_rs_i[i] && (rs_id_i[i*5 +: 5] != 5'd0) && valid_q[rs_id_i[i*5 +: 5]]) begin
        if (long_q[rs_id_i[i*5 +: 5]]) begin
          long_stall[i] = 1'b1;
        end else if (age_q[rs_id_i[i*5 +: 5]] >= rdy_q[rs_id_i[i*5 +: 5]]) begin
          bypass_sel_o[i*SEL_W +: SEL_W] = SEL_W'(age_q[rs_id_i[i*5 +: 5]]) + SEL_W'(1);
        end else begin
          // Result not yet bypassable (load-use, or ready_age beyond the last buffer).
          ld_stall[i] = 1'b1;
        end
      end
    end
    waw_stall  = issue_valid_i && issue_wb_i && (issue_rd_i != 5'd0) &&
                 valid_q[issue_rd_i] && long_q[issue_rd_i];
    stall_o    = (|long_stall) || (|ld_stall) || waw_stall;
    issue_fire = issue_valid_i && issue_wb_i && pipe_advance_i && !stall_o &&
                 (issue_rd_i != 5'd0);
  end

  // Next-state: age in-pipe entries, retire long ops, then record the newly issued producer.
  always_comb begin
    valid_d = valid_q;
    long_d  = long_q;
    age_d   = age_q;
    rdy_d   = rdy_q;
    if (pipe_advance_i) begin
      for (int r = 1; r < 32; r++) begin
        if (valid_q[r] && !long_q[r]) begin
          if (age_q[r] == LastAge) begin
            // Leaves the last buffer; regfile write-first covers the next read.
            valid_d[r] = 1'b0;
            age_d[r]   = '0;
          end else begin
            age_d[r] = age_q[r] + AGE_W'(1);
          end
        end
      end
    end
    if (lu_done_i && (lu_rd_i != 5'd0) && valid_q[lu_rd_i] && long_q[lu_rd_i]) begin
      valid_d[lu_rd_i] = 1'b0;
      long_d[lu_rd_i]  = 1'b0;
    end
    // Youngest producer overwrites any older in-pipe entry for the same rd.
    if (issue_fire) begin
      valid_d[issue_rd_i] = 1'b1;
      long_d[issue_rd_i]  = issue_long_i;
      age_d[issue_rd_i]   = '0;
      rdy_d[issue_rd_i]   = issue_ready_age_i;
    end
  end

  // Scoreboard state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      long_q  <= '0;
      age_q   <= '{default: '0};
      rdy_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      long_q  <= long_d;
      age_q   <= age_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef RV32_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, loaduse_cnt_q, waw_cnt_q;

  // Free-running hazard counters; wrap naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q   <= '0;
      loaduse_cnt_q <= '0;
      waw_cnt_q     <= '0;
    end else begin
      if (stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (|ld_stall) loaduse_cnt_q <= loaduse_cnt_q + 32'd1;
      if (waw_stall && !(|long_stall) && !(|ld_stall)) waw_cnt_q <= waw_cnt_q + 32'd1;
    end
  end

  assign stat_stall_cycles_o = stall_cnt_q;
  assign stat_loaduse_o      = loaduse_cnt_q;
  assign stat_waw_o          = waw_cnt_q;
`endif

endmodule
